// File: rtl/stage4.sv
// stage4: multi-day term tracker with probation/strike FSM and graduation result.
// Optional honours credit tracking is enabled by defining STAGE4_HONORS_EN.
module stage4 #(
  parameter int unsigned DAYS       = 16,
  parameter int unsigned MAX_FAIL   = 3,
  parameter int unsigned STRIKES    = 2,
  parameter int unsigned PASS_NEED  = 12,
  parameter int unsigned HONOR_NEED = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       day_valid,
  output logic       day_ready,
  input  logic       pass3,
  input  logic [1:0] bonus2,
  output logic       busy,
  output logic       on_probation,
  output logic       done,
  output logic       graduated,
  output logic       dismissed,
  output logic       honors,
  output logic [7:0] day_cnt,
  output logic [7:0] pass_cnt
);

  typedef enum logic [1:0] {IDLE, TERM, PROB, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] streak, streak_n;
  logic [7:0] strikes, strikes_n;
  logic [7:0] day_n, pass_n;
  logic       grad_n, dism_n;
  logic       accept;

  assign accept = day_valid & day_ready;

`ifdef STAGE4_HONORS_EN
  logic [7:0] credit, credit_n;
  logic [8:0] credit_sum;
  logic       hon_n;

  assign credit_sum = {1'b0, credit} + {7'b0, bonus2};
`else
  logic unused_cfg;

  assign unused_cfg = ^{bonus2, 32'(HONOR_NEED)};
  assign honors     = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    streak_n  = streak;
    strikes_n = strikes;
    day_n     = day_cnt;
    pass_n    = pass_cnt;
    grad_n    = graduated;
    dism_n    = dismissed;
`ifdef STAGE4_HONORS_EN
    credit_n  = credit;
    hon_n     = honors;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = TERM;
          streak_n  = '0;
          strikes_n = '0;
          day_n     = '0;
          pass_n    = '0;
          grad_n    = 1'b0;
          dism_n    = 1'b0;
`ifdef STAGE4_HONORS_EN
          credit_n  = '0;
          hon_n     = 1'b0;
`endif
        end
      end
      default: begin
        if (accept) begin
          day_n = day_cnt + 8'd1;
          if (pass3) begin
            pass_n   = pass_cnt + 8'd1;
            streak_n = '0;
`ifdef STAGE4_HONORS_EN
            credit_n = credit_sum[8] ? '1 : credit_sum[7:0];
`endif
            if (state == PROB) state_n = TERM;
          end else begin
            streak_n = streak + 8'd1;
            if (state == TERM && 32'(streak_n) == MAX_FAIL) begin
              state_n  = PROB;
              streak_n = '0;
            end
            if (state == PROB) begin
              strikes_n = strikes + 8'd1;
              if (32'(strikes_n) == STRIKES) begin
                dism_n  = 1'b1;
                state_n = DONE;
              end
            end
          end
          // Dismissal takes precedence over a coincident last day.
          if (!dism_n && 32'(day_n) == DAYS) begin
            state_n = DONE;
            grad_n  = 32'(pass_n) >= PASS_NEED;
`ifdef STAGE4_HONORS_EN
            hon_n   = grad_n && (32'(credit_n) >= HONOR_NEED);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      streak       <= '0;
      strikes      <= '0;
      day_cnt      <= '0;
      pass_cnt     <= '0;
      graduated    <= 1'b0;
      dismissed    <= 1'b0;
      day_ready    <= 1'b0;
      busy         <= 1'b0;
      on_probation <= 1'b0;
      done         <= 1'b0;
`ifdef STAGE4_HONORS_EN
      credit       <= '0;
      honors       <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      streak       <= streak_n;
      strikes      <= strikes_n;
      day_cnt      <= day_n;
      pass_cnt     <= pass_n;
      graduated    <= grad_n;
      dismissed    <= dism_n;
      day_ready    <= (state_n == TERM) || (state_n == PROB);
      busy         <= (state_n == TERM) || (state_n == PROB);
      on_probation <= (state_n == PROB);
      done         <= (state_n == DONE);
`ifdef STAGE4_HONORS_EN
      credit       <= credit_n;
      honors       <= hon_n;
`endif
    end
  end

endmodule

// File: tb/tb_stage4.sv
// Bench for stage4: directed term scenarios plus random traffic, each cycle
// compared against a behavioural model of the term rules.
module tb_stage4;

  logic       clk = 1'b0;
  logic       rst_n, start, day_valid, pass3;
  logic [1:0] bonus2;
  logic       day_ready, busy, on_probation, done, graduated, dismissed, honors;
  logic [7:0] day_cnt, pass_cnt;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit m_active, m_prob, m_done, m_grad, m_dism, m_hon;
  int m_day, m_pass, m_streak, m_strikes, m_credit;

  bit prob_hist[16];
  bit busy_hist[16];

  stage4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .day_valid(day_valid),
    .day_ready(day_ready), .pass3(pass3), .bonus2(bonus2), .busy(busy),
    .on_probation(on_probation), .done(done), .graduated(graduated),
    .dismissed(dismissed), .honors(honors), .day_cnt(day_cnt), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_active = 0; m_prob = 0; m_done = 0; m_grad = 0; m_dism = 0; m_hon = 0;
      m_day = 0; m_pass = 0; m_streak = 0; m_strikes = 0; m_credit = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_prob = 0; m_done = 0; m_grad = 0; m_dism = 0; m_hon = 0;
        m_day = 0; m_pass = 0; m_streak = 0; m_strikes = 0; m_credit = 0;
      end
    end else if (day_valid) begin
      m_day++;
      if (pass3) begin
        m_pass++;
        m_streak = 0;
        m_credit = (m_credit + int'(bonus2) > 255) ? 255 : m_credit + int'(bonus2);
        m_prob = 0;
      end else if (m_prob) begin
        m_strikes++;
        if (m_strikes == 2) m_dism = 1;
      end else begin
        m_streak++;
        if (m_streak == 3) begin
          m_prob = 1;
          m_streak = 0;
        end
      end
      if (m_dism || m_day == 16) begin
        m_active = 0;
        m_prob = 0;
        m_done = 1;
        m_grad = !m_dism && m_pass >= 12;
`ifdef STAGE4_HONORS_EN
        m_hon = m_grad && m_credit >= 20;
`endif
      end
    end
  endtask

  task automatic check_all();
    chk("day_ready", 32'(day_ready), 32'(m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("on_probation", 32'(on_probation), 32'(m_prob));
    chk("done", 32'(done), 32'(m_done));
    chk("graduated", 32'(graduated), 32'(m_grad));
    chk("dismissed", 32'(dismissed), 32'(m_dism));
    chk("honors", 32'(honors), 32'(m_hon));
    chk("day_cnt", 32'(day_cnt), 32'(m_day));
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // start pulse, then 16 back-to-back day offers; bit i of pat = verdict of day i+1
  task automatic run_term(input logic [15:0] pat, input logic [1:0] b);
    start = 1; day_valid = 0;
    cyc();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      day_valid = 1; pass3 = pat[i]; bonus2 = b;
      cyc();
      prob_hist[i] = on_probation;
      busy_hist[i] = busy;
    end
    day_valid = 0;
    cyc();
  endtask

  initial begin
    bit any_prob;
    bit all_busy;
    rst_n = 0; start = 0; day_valid = 0; pass3 = 0; bonus2 = 0;
    cyc();
    cyc();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_day_cnt", 32'(day_cnt), 0);
    rst_n = 1;

    // day offers in IDLE are dropped
    day_valid = 1; pass3 = 1;
    cyc(); cyc(); cyc();
    chk("idle_drop_day_cnt", 32'(day_cnt), 0);
    day_valid = 0;

    // clean graduation
    run_term(16'hFFFF, 2'd2);
    chk("clean_pass_cnt", 32'(pass_cnt), 16);
    chk("clean_day_cnt", 32'(day_cnt), 16);
    chk("clean_grad", 32'(graduated), 1);
`ifdef STAGE4_HONORS_EN
    chk("clean_honors", 32'(honors), 1);
`else
    chk("clean_honors", 32'(honors), 0);
`endif

    // probation round-trip
    run_term(16'hFFF8, 2'd1);
    chk("prob_after_d3", 32'(prob_hist[2]), 1);
    chk("prob_after_d4", 32'(prob_hist[3]), 0);
    all_busy = 1;
    for (int i = 0; i < 15; i++) all_busy &= busy_hist[i];
    chk("prob_busy_held", 32'(all_busy), 1);

    // dismissal on day 5
    run_term(16'hFFE0, 2'd3);
    chk("dism_flag", 32'(dismissed), 1);
    chk("dism_done", 32'(done), 1);
    chk("dism_day_cnt", 32'(day_cnt), 5);
    chk("dism_ready", 32'(day_ready), 0);

    // insufficient passes: fails on days 3,6,9,12,15
    run_term(16'hB6DB, 2'd3);
    any_prob = 0;
    for (int i = 0; i < 16; i++) any_prob |= prob_hist[i];
    chk("insuf_pass_cnt", 32'(pass_cnt), 11);
    chk("insuf_grad", 32'(graduated), 0);
    chk("insuf_dism", 32'(dismissed), 0);
    chk("insuf_done", 32'(done), 1);
    chk("insuf_no_prob", 32'(any_prob), 0);

    // last-day collision with dismissal
    run_term(16'h07FF, 2'd3);
    chk("coll_prob_d14", 32'(prob_hist[13]), 1);
    chk("coll_dism", 32'(dismissed), 1);
    chk("coll_grad", 32'(graduated), 0);
    chk("coll_day_cnt", 32'(day_cnt), 16);

    // start mid-term ignored, then reset after day 7 with start/valid asserted
    start = 1; day_valid = 0;
    cyc();
    start = 0;
    for (int i = 0; i < 7; i++) begin
      day_valid = 1; pass3 = 1; bonus2 = 2'd1;
      start = (i == 2);
      cyc();
    end
    start = 0;
    chk("midstart_day_cnt", 32'(day_cnt), 7);
    rst_n = 0; start = 1; day_valid = 1;
    cyc();
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_day_cnt", 32'(day_cnt), 0);
    rst_n = 1; start = 0; day_valid = 0;
    cyc();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      start     = ($urandom_range(0, 19) == 0);
      day_valid = ($urandom_range(0, 3) != 0);
      pass3     = ($urandom_range(0, 9) < 7);
      bonus2    = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage4.md
# stage4

Sequential term tracker sitting directly downstream of `stage3`. Each cycle-accepted "day" consumes one `pass3` verdict plus the `bonus2` grade from `stage2`, and the block accumulates the results over a term. It runs a probation/strike state machine and reports final graduation, dismissal and optional honours status. It turns the per-day combinational game chain into a multi-day outcome.

## Interface
Parameters:
- `DAYS`, 16: days per term (1..255).
- `MAX_FAIL`, 3: consecutive failed days in normal standing that trigger probation (1..255).
- `STRIKES`, 2: failed days while on probation that cause dismissal (1..255).
- `PASS_NEED`, 12: passed days required to graduate.
- `HONOR_NEED`, 20: credit total required for honours.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a new term; pulse.
- `day_valid` in 1: a day result is presented.
- `day_ready` out 1: block accepts a day this cycle.
- `pass3` in 1: day verdict from `stage3`; 1 means the day passed.
- `bonus2` in 2: day grade from `stage2`.
- `busy` out 1: term in progress (TERM or PROB).
- `on_probation` out 1: state is PROB.
- `done` out 1: term finished; held.
- `graduated` out 1: valid while `done`.
- `dismissed` out 1: valid while `done`.
- `honors` out 1: valid while `done`.
- `day_cnt` out 8: accepted days this term.
- `pass_cnt` out 8: passed days this term.

## Operation
- States: IDLE, TERM, PROB, DONE.
- Accept condition: `day_valid & day_ready`. `day_ready` = 1 only in TERM and PROB. `day_valid` in any other state is dropped, with no buffering.
- IDLE or DONE with `start`=1:
  - Clear `day_cnt`, `pass_cnt`, the fail streak, the strike count, the credit total and all result flags.
  - Next state is TERM.
- `start` in TERM or PROB is ignored.
- On each accept:
  - `day_cnt` increments by 1.
  - If `pass3`=1: `pass_cnt` increments by 1 and the fail streak clears.
  - If `pass3`=0: the fail streak increments by 1.
- TERM transitions:
  - Fail that brings the streak to `MAX_FAIL`: go to PROB and clear the streak.
- PROB transitions:
  - Pass: return to TERM.
  - Fail: strike count increments by 1.
  - Strike count reaching `STRIKES`: set `dismissed`=1 and go to DONE.
- Strike count is never cleared within a term.
- After any accept where the updated `day_cnt` == `DAYS` and the block is not dismissed:
  - Go to DONE.
  - `graduated` = (updated `pass_cnt` >= `PASS_NEED`).
- Simultaneous last day and dismissal: dismissal wins, so `graduated`=0 and `dismissed`=1.
- Simultaneous last day and entry to probation: go to DONE; graduation is evaluated normally.
- DONE:
  - `done`=1.
  - All counters and flags hold until `start` or reset.
  - A `start` here begins a new term.
- Counter width is 8 bits. Counters cannot wrap because `DAYS` <= 255 bounds them.

## Timing
- All outputs are registered and update on the rising edge after the accept or `start` cycle.
- Latency:
  - `start` to `busy`=1 and `day_ready`=1: 1 cycle.
  - Final accept to `done`=1: 1 cycle. `day_ready` drops in the same cycle.
- Full throughput: one day may be accepted every cycle.
- Reset (`rst_n`=0 at a clock edge, including mid-term):
  - State goes to IDLE.
  - Every output is 0: `day_ready`, `busy`, `on_probation`, `done`, `graduated`, `dismissed`, `honors`, `day_cnt`=0, `pass_cnt`=0.
  - Internal streak, strike count and credit total are 0.
- Reset has priority over `start` and `day_valid` in the same cycle.

## Configuration
- Macro: `STAGE4_HONORS_EN`.
- Defined:
  - An 8-bit credit register adds `bonus2` on each accepted passed day. Failed days add nothing. The register saturates at 255.
  - At term end, `honors` = `graduated` & (credit >= `HONOR_NEED`).
  - `honors` is set only in the transition to DONE.
- Undefined:
  - No credit register.
  - `bonus2` is ignored.
  - `honors` is tied to 0.

## Test plan
All scenarios use default parameters.
- Clean graduation: reset, `start`, then 16 days back-to-back with `pass3`=1 and `bonus2`=2.
  - `done`=1 exactly one cycle after the 16th accept.
  - `pass_cnt`=16, `day_cnt`=16, `graduated`=1.
  - `honors`=1 with the macro (credit 32); `honors`=0 without it.
- Probation round-trip: fails on days 1-3, then pass on day 4.
  - `on_probation`=1 after day 3.
  - `on_probation`=0 after day 4.
  - `busy` stays 1 throughout.
- Dismissal: fails on days 1-5.
  - Probation after day 3, strikes on days 4 and 5.
  - After day 5: `dismissed`=1, `done`=1, `day_cnt`=5, `day_ready`=0.
- Insufficient passes: fails on days 3, 6, 9, 12 and 15 only.
  - Result: `pass_cnt`=11, `graduated`=0, `dismissed`=0, `done`=1, `on_probation` never asserted.
- Last-day collision: passes on days 1-11, fails on days 12-16.
  - Probation after day 14, strikes on days 15 and 16.
  - Final: `dismissed`=1, `graduated`=0, `day_cnt`=16.
- Control corner cases:
  - `day_valid`=1 in IDLE: `day_cnt` stays 0.
  - `start` mid-term: ignored, counts continue.
  - `rst_n`=0 after day 7: all outputs 0 next cycle, state IDLE.
